branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Controller that drives the Branch_Unit's prediction and flush-correction inputs.
- Holds a PC-indexed table of 2-bit saturating counters that supplies the taken/not-taken prediction for a branch in ID.
- Carries each predicted branch into EX, compares the prediction with the resolved outcome, and raises a one-cycle flush with the correct PC on a mispredict.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 2, log2 of counter-table entries; index = PC[INDEX_BITS+1:2].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- stall_i  in  1  load-use stall; ID holds and EX receives a bubble.
- ID_Branch_i  in  1  instruction in ID is a conditional branch.
- ID_PC_i  in  32  PC of the instruction in ID.
- ID_immExtended_i  in  32  sign-extended branch immediate, in halfword units.
- EX_Taken_i  in  1  resolved branch outcome in EX; ignored unless an EX branch is valid.
- Predict_o  in  out  1  prediction for the ID branch (to Branch_Unit Predict_i).
- Flush_o  out  1  mispredict flush of IF/ID/EX (to Branch_Unit IF_ID_EX_Flush_i).
- PC_Correct_o  out  32  recovery PC (to Branch_Unit PC_Correct_i).
- Branch_Cnt_o  out  CNT_W  number of resolved branches.
- Mispredict_Cnt_o  out  CNT_W  number of mispredicts.

Behaviour:
- Reset, synchronous on clk_i with rst_i=1:
  - All 2^INDEX_BITS table entries = 2'b11 (strongly taken).
  - ex_valid = 0, ex_pred = 0, ex_index = 0, ex_target = 0, ex_fall = 0.
  - Both statistics counters = 0.
  - Reset overrides every other event in that cycle, including an in-flight branch mid-resolution; no table update and no count.
- Counter FSM per entry:
  - States: SNT=00, WNT=01, WT=10, ST=11. Predict taken when MSB=1.
  - If taken: SNT->WNT->WT->ST, and ST stays ST.
  - If not taken: ST->WT->WNT->SNT, and SNT stays SNT.
- Predict_o (combinational):
  - Predict_o = ID_Branch_i & table[ID_PC_i[INDEX_BITS+1:2]][1].
  - Predict_o = 0 when ID_Branch_i = 0.
- ID->EX capture, at each clock edge with no reset:
  - If Flush_o=1 or stall_i=1: ex_valid <= 0 (flushed or bubbled ID slot).
  - Otherwise:
    - ex_valid <= ID_Branch_i
    - ex_pred <= Predict_o
    - ex_index <= ID index
    - ex_fall <= ID_PC_i + 4
    - ex_target <= ID_PC_i + (ID_immExtended_i << 1)
  - All arithmetic is mod 2^32; wrap-around is not flagged.
  - A stalled branch stays in ID and is captured on the first non-stalled edge.
- Resolution (combinational in the EX cycle, i.e. one cycle after capture):
  - Flush_o = ex_valid & (EX_Taken_i != ex_pred).
  - PC_Correct_o = !ex_valid ? 0 : (EX_Taken_i ? ex_target : ex_fall).
  - Flush_o is therefore a single-cycle pulse per mispredicted branch.
- Update, at the edge ending a cycle with ex_valid=1:
  - table[ex_index] steps per EX_Taken_i.
  - Branch_Cnt increments.
  - Mispredict_Cnt increments when Flush_o=1.
  - Both statistics counters saturate at all-ones.
  - The EX update happens even when stall_i=1.
- Same-index read/write in one cycle:
  - The ID read sees the pre-update value; there is no bypass.
  - The written value is visible from the next cycle.
- Back-to-back branches:
  - A correctly predicted branch in EX does not disturb the capture of a following ID branch.
  - A mispredicted branch in EX discards the ID branch: no capture and no table update for it.
- Latency:
  - Predict_o: 0 cycles.
  - Flush_o and PC_Correct_o: 1 cycle after ID capture.
  - Table and statistics: visible 2 cycles after ID.

Test Plan:
- Reset then ID_Branch_i=1, PC=0x40 -> Predict_o=1. Next cycle EX_Taken_i=1 -> Flush_o=0, PC_Correct_o=0x40+(imm<<1), entry 0 stays 11, Branch_Cnt_o=1.
- Same PC/index, 3 consecutive not-taken resolutions -> entry 11->10->01->00. Flush_o pulses on the first two only, Predict_o=0 afterwards, Mispredict_Cnt_o=2. Then taken with imm=0x10 -> Flush_o=1, PC_Correct_o=0x60.
- Mispredicted branch in EX while another branch sits in ID -> next cycle ex_valid=0, Flush_o=0, that ID branch not counted.
- stall_i=1 with a branch in ID for 2 cycles -> no Flush_o during the stall. Branch captured on the first non-stalled edge and resolved the following cycle.
- EX update to index 1 coincides with an ID read of index 1 -> Predict_o reflects the old value. The next access reflects the new value.
- rst_i=1 during a mispredict cycle -> Flush_o next cycle 0, counters 0, all entries 11. Force Branch_Cnt to all-ones and resolve one more branch -> value holds at all-ones.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : 2-bit saturating-counter branch predictor with EX-stage
//            mispredict detection, flush/recovery PC and statistics.
// Revision : 1.0
// ============================================================================
module branch_predict_ctrl #(
    parameter int INDEX_BITS = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             ID_Branch_i,
    input  logic [31:0]      ID_PC_i,
    input  logic [31:0]      ID_immExtended_i,
    input  logic             EX_Taken_i,
    output logic             Predict_o,
    output logic             Flush_o,
    output logic [31:0]      PC_Correct_o,
    output logic [CNT_W-1:0] Branch_Cnt_o,
    output logic [CNT_W-1:0] Mispredict_Cnt_o
);

    localparam int               c_ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } counter_state_t;

    counter_state_t        r_table [c_ENTRIES];
    logic                  r_ex_valid;
    logic                  r_ex_pred;
    logic [INDEX_BITS-1:0] r_ex_index;
    logic [31:0]           r_ex_target;
    logic [31:0]           r_ex_fall;
    logic [CNT_W-1:0]      r_branch_cnt;
    logic [CNT_W-1:0]      r_mispredict_cnt;

    logic [INDEX_BITS-1:0] w_id_index;
    counter_state_t        w_cur_state;
    counter_state_t        w_next_state;

    assign w_id_index = ID_PC_i[INDEX_BITS+1:2];
    assign w_cur_state = r_table[r_ex_index];

    // Saturating counter step for the entry owned by the branch in EX
    always_comb begin
        w_next_state = w_cur_state;
        case (w_cur_state)
            SNT:     w_next_state = EX_Taken_i ? WNT : SNT;
            WNT:     w_next_state = EX_Taken_i ? WT  : SNT;
            WT:      w_next_state = EX_Taken_i ? ST  : WNT;
            ST:      w_next_state = EX_Taken_i ? ST  : WT;
            default: w_next_state = ST;
        endcase
    end

    assign Predict_o        = ID_Branch_i & r_table[w_id_index][1];
    assign Flush_o          = r_ex_valid & (EX_Taken_i != r_ex_pred);
    assign PC_Correct_o     = !r_ex_valid ? 32'd0 : (EX_Taken_i ? r_ex_target : r_ex_fall);
    assign Branch_Cnt_o     = r_branch_cnt;
    assign Mispredict_Cnt_o = r_mispredict_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= ST;
            end
            r_ex_valid       <= 1'b0;
            r_ex_pred        <= 1'b0;
            r_ex_index       <= '0;
            r_ex_target      <= 32'd0;
            r_ex_fall        <= 32'd0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            // EX retirement proceeds regardless of the ID stall
            if (r_ex_valid) begin
                r_table[r_ex_index] <= w_next_state;
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
                end
                if (Flush_o && (r_mispredict_cnt != '1)) begin
                    r_mispredict_cnt <= r_mispredict_cnt + c_CNT_ONE;
                end
            end

            if (Flush_o || stall_i) begin
                r_ex_valid <= 1'b0;
            end else begin
                r_ex_valid  <= ID_Branch_i;
                r_ex_pred   <= Predict_o;
                r_ex_index  <= w_id_index;
                r_ex_fall   <= ID_PC_i + 32'd4;
                r_ex_target <= ID_PC_i + (ID_immExtended_i << 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Brief    : Directed + random bench for branch_predict_ctrl against a
//            behavioural pipeline/predictor model.
// Revision : 1.0
// ============================================================================
module tb_branch_predict_ctrl;

    localparam int INDEX_BITS = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk_i;
    logic             rst_i;
    logic             stall_i;
    logic             ID_Branch_i;
    logic [31:0]      ID_PC_i;
    logic [31:0]      ID_immExtended_i;
    logic             EX_Taken_i;
    logic             Predict_o;
    logic             Flush_o;
    logic [31:0]      PC_Correct_o;
    logic [CNT_W-1:0] Branch_Cnt_o;
    logic [CNT_W-1:0] Mispredict_Cnt_o;

    branch_predict_ctrl #(
        .INDEX_BITS(INDEX_BITS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .ID_Branch_i     (ID_Branch_i),
        .ID_PC_i         (ID_PC_i),
        .ID_immExtended_i(ID_immExtended_i),
        .EX_Taken_i      (EX_Taken_i),
        .Predict_o       (Predict_o),
        .Flush_o         (Flush_o),
        .PC_Correct_o    (PC_Correct_o),
        .Branch_Cnt_o    (Branch_Cnt_o),
        .Mispredict_Cnt_o(Mispredict_Cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    // Model: counter strength 0..3 per entry, plus the branch sitting in EX
    int          m_tbl [4];
    bit          m_valid;
    bit          m_pred;
    int          m_idx;
    logic [31:0] m_tgt;
    logic [31:0] m_fall;
    int          m_bc;
    int          m_mc;

    logic        obs_pred;
    logic        obs_flush;
    logic [31:0] obs_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_tbl[i] = 3;
        m_valid = 0;
        m_pred  = 0;
        m_idx   = 0;
        m_tgt   = 32'd0;
        m_fall  = 32'd0;
        m_bc    = 0;
        m_mc    = 0;
    endtask

    task automatic step(input bit rst, input bit stall, input bit br,
                        input logic [31:0] pc, input logic [31:0] imm, input bit taken);
        bit          e_pred;
        bit          e_flush;
        logic [31:0] e_pc;
        int          idx;
        @(negedge clk_i);
        rst_i            = rst;
        stall_i          = stall;
        ID_Branch_i      = br;
        ID_PC_i          = pc;
        ID_immExtended_i = imm;
        EX_Taken_i       = taken;
        #1;
        idx     = int'(pc[3:2]);
        e_pred  = br && (m_tbl[idx] >= 2);
        e_flush = m_valid && (taken != m_pred);
        e_pc    = !m_valid ? 32'd0 : (taken ? m_tgt : m_fall);
        obs_pred  = Predict_o;
        obs_flush = Flush_o;
        obs_pc    = PC_Correct_o;
        if (armed) begin
            check("predict",    32'(Predict_o),        32'(e_pred));
            check("flush",      32'(Flush_o),          32'(e_flush));
            check("pc_correct", PC_Correct_o,          e_pc);
            check("branch_cnt", 32'(Branch_Cnt_o),     32'(m_bc));
            check("mispred_cnt",32'(Mispredict_Cnt_o), 32'(m_mc));
        end
        @(posedge clk_i);
        if (rst) begin
            model_reset();
            armed = 1;
        end else begin
            if (m_valid) begin
                if (taken) m_tbl[m_idx] = (m_tbl[m_idx] == 3) ? 3 : m_tbl[m_idx] + 1;
                else       m_tbl[m_idx] = (m_tbl[m_idx] == 0) ? 0 : m_tbl[m_idx] - 1;
                if (m_bc < CNT_MAX) m_bc++;
                if (e_flush && m_mc < CNT_MAX) m_mc++;
            end
            if (e_flush || stall) begin
                m_valid = 0;
            end else begin
                m_valid = br;
                m_pred  = e_pred;
                m_idx   = idx;
                m_fall  = pc + 32'd4;
                m_tgt   = pc + (imm << 1);
            end
        end
    endtask

    bit flushes [3];

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; ID_Branch_i = 1'b0;
        ID_PC_i = 32'd0; ID_immExtended_i = 32'd0; EX_Taken_i = 1'b0;

        step(1, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0);

        // Fresh table predicts taken; correct taken resolution
        step(0, 0, 1, 32'h40, 32'h8, 0);
        check("reset_predict_taken", 32'(obs_pred), 32'd1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("first_flush", 32'(obs_flush), 32'd0);
        check("first_target", obs_pc, 32'h50);

        // Three not-taken resolutions walk the entry down to SNT
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 32'h40, 32'h8, 0);
            step(0, 0, 0, 32'h0, 32'h0, 0);
            flushes[i] = obs_flush;
        end
        check("nt_flush0", 32'(flushes[0]), 32'd1);
        check("nt_flush1", 32'(flushes[1]), 32'd1);
        check("nt_flush2", 32'(flushes[2]), 32'd0);
        step(0, 0, 1, 32'h40, 32'h10, 0);
        check("snt_predict", 32'(obs_pred), 32'd0);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("snt_taken_flush", 32'(obs_flush), 32'd1);
        check("snt_taken_pc", obs_pc, 32'h60);

        // Mispredict in EX discards the branch in ID
        step(0, 0, 1, 32'h40, 32'h4, 0);
        step(0, 0, 1, 32'h44, 32'h4, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        check("discard_no_flush", 32'(obs_flush), 32'd0);

        // Stalled branch captured on first free edge
        step(0, 1, 1, 32'h48, 32'h6, 0);
        step(0, 1, 1, 32'h48, 32'h6, 0);
        step(0, 0, 1, 32'h48, 32'h6, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0);

        // Same-index update and read in one cycle
        step(0, 0, 1, 32'h44, 32'h2, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 1, 32'h44, 32'h2, 0);
        step(0, 0, 1, 32'h54, 32'h2, 0);
        check("same_index_old_value", 32'(obs_pred), 32'd1);
        step(0, 0, 1, 32'h54, 32'h2, 0);
        check("same_index_new_value", 32'(obs_pred), 32'd0);
        step(0, 0, 0, 32'h0, 32'h0, 0);

        // Reset during a mispredict cycle
        step(0, 0, 1, 32'h40, 32'h3, 0);
        step(1, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 1, 32'h0, 32'h1, 1);
        check("post_reset_flush", 32'(obs_flush), 32'd0);
        step(0, 0, 1, 32'h4, 32'h1, 1);
        step(0, 0, 1, 32'h8, 32'h1, 1);
        step(0, 0, 1, 32'hC, 32'h1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Random traffic; small counters saturate along the way
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 6,
                 {$urandom_range(0, 15) == 0 ? 28'hFFFFFFF : 28'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 2'b00},
                 $urandom,
                 $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
